// File: rtl/score_pkg.sv
// Shared constants, types and helpers for the score display controller.
package score_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_t;

  // Active-low segments, bit order gfedcba.
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_NINE  = 7'b0010000;

  function automatic logic [31:0] pow10(input int n);
    logic [31:0] r;
    r = 32'd1;
    for (int i = 0; i < n; i++) r = r * 32'd10;
    return r;
  endfunction

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] r;
    case (d)
      4'd0:    r = SEG_DIGIT[0];
      4'd1:    r = SEG_DIGIT[1];
      4'd2:    r = SEG_DIGIT[2];
      4'd3:    r = SEG_DIGIT[3];
      4'd4:    r = SEG_DIGIT[4];
      4'd5:    r = SEG_DIGIT[5];
      4'd6:    r = SEG_DIGIT[6];
      4'd7:    r = SEG_DIGIT[7];
      4'd8:    r = SEG_DIGIT[8];
      4'd9:    r = SEG_NINE;
      default: r = SEG_BLANK;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/score_display_ctrl_bin2bcd.sv
// Sequential shift-add-3 binary to BCD converter, one input bit per clock.
module bin2bcd_seq #(
  parameter int BIN_W = 14,
  parameter int BCD_W = 20
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [BIN_W-1:0] bin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [BCD_W-1:0] bcd_o
);
  localparam int CNT_W = $clog2(BIN_W + 1);

  logic [BIN_W-1:0] sh_q;
  logic [BCD_W-1:0] acc_q;
  logic [BCD_W-1:0] adj_s;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  always_comb begin
    adj_s = acc_q;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) adj_s[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      else                         adj_s[4*i +: 4] = acc_q[4*i +: 4];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sh_q   <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i && !busy_q) begin
      sh_q   <= bin_i;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      acc_q <= (adj_s << 1) | BCD_W'(sh_q[BIN_W-1]);
      sh_q  <= sh_q << 1;
      cnt_q <= cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(BIN_W - 1)) busy_q <= 1'b0;
    end
  end

  assign busy_o = busy_q;
  assign done_o = busy_q && (cnt_q == CNT_W'(BIN_W - 1));
  assign bcd_o  = acc_q;
endmodule

// File: rtl/score_display_ctrl.sv
// Score readout: capture/commit FSM around the BCD converter, seven-segment
// encoding with leading-zero blanking, and a tear-free 8x8 bar-graph scan.
module score_display_ctrl
  import score_pkg::*;
#(
  parameter int SCORE_W    = 14,
  parameter int NUM_DIGITS = 4,
  parameter int LEAD_BLANK = 1,
  parameter int UNIT_LOG2  = 7,
  parameter int SCAN_DIV   = 1
) (
  input  logic                    clk2,
  input  logic                    reset,
  input  logic [SCORE_W-1:0]      score,
  output logic [7*NUM_DIGITS-1:0] seven,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic                    overflow,
  output logic                    conv_busy,
  output logic [7:0]              dot_col,
  output logic [7:0]              dot_row
);
  localparam int          BCD_W   = 4 * NUM_DIGITS + 4;
  localparam logic [31:0] OVF_LIM = pow10(NUM_DIGITS);
  localparam int          PS_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  function automatic logic [7*NUM_DIGITS-1:0] seven_rst();
    logic [7*NUM_DIGITS-1:0] r;
    for (int i = 0; i < NUM_DIGITS; i++)
      r[7*i +: 7] = (i == 0 || LEAD_BLANK == 0) ? SEG_DIGIT[0] : SEG_BLANK;
    return r;
  endfunction
  localparam logic [7*NUM_DIGITS-1:0] SEVEN_RST = seven_rst();

  conv_state_t             state_q;
  logic [SCORE_W-1:0]      last_q;
  logic                    last_vld_q, busy_q, ovf_q;
  logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
  logic [7*NUM_DIGITS-1:0] seven_q, seven_d;
  logic [6:0]              pend_q, bar_d, frame_q;
  logic                    ovf_d, blank_s, start_s, cv_busy_s, cv_done_s;
  logic [BCD_W-1:0]        cv_bcd_s;
  logic [31:0]             units_s;
  logic [PS_W-1:0]         presc_q;
  logic [2:0]              row_q;
  logic [3:0]              full_s;
  logic [7:0]              dot_col_q, dot_row_q, col_d;

  assign start_s = (state_q == ST_IDLE) && !cv_busy_s && (!last_vld_q || score != last_q);

  bin2bcd_seq #(.BIN_W(SCORE_W), .BCD_W(BCD_W)) u_bcd (
    .clk_i(clk2), .rst_i(reset), .start_i(start_s), .bin_i(score),
    .busy_o(cv_busy_s), .done_o(cv_done_s), .bcd_o(cv_bcd_s)
  );

  // Values written at COMMIT; blanking walks down from the top digit.
  always_comb begin
    ovf_d = (32'(last_q) >= OVF_LIM) || (cv_bcd_s[BCD_W-1 -: 4] != 4'd0);
    if (ovf_d) bcd_d = {NUM_DIGITS{4'd9}};
    else       bcd_d = cv_bcd_s[4*NUM_DIGITS-1:0];
    blank_s = (LEAD_BLANK != 0) && !ovf_d;
    seven_d = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      blank_s = blank_s && (i > 0) && (bcd_d[4*i +: 4] == 4'd0);
      seven_d[7*i +: 7] = blank_s ? SEG_BLANK : seg_encode(bcd_d[4*i +: 4]);
    end
    units_s = 32'(last_q) >> UNIT_LOG2;
    if (units_s > 32'd64) bar_d = 7'd64;
    else                  bar_d = units_s[6:0];
  end

  // Conversion FSM: capture, wait for the converter, commit.
  always_ff @(posedge clk2) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      last_q     <= '0;
      last_vld_q <= 1'b0;
      busy_q     <= 1'b0;
      bcd_q      <= '0;
      seven_q    <= SEVEN_RST;
      ovf_q      <= 1'b0;
      pend_q     <= 7'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_s) begin
            last_q     <= score;
            last_vld_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cv_done_s) state_q <= ST_COMMIT;
        end
        ST_COMMIT: begin
          bcd_q   <= bcd_d;
          seven_q <= seven_d;
          ovf_q   <= ovf_d;
          pend_q  <= bar_d;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    full_s = frame_q[6:3];
    if ({1'b0, row_q} < full_s)       col_d = 8'hFF;
    else if ({1'b0, row_q} == full_s) col_d = ~(8'hFF >> frame_q[2:0]);
    else                              col_d = 8'h00;
  end

  // Row scan; the frame value swaps only as the scan wraps 7 -> 0.
  always_ff @(posedge clk2) begin
    if (reset) begin
      presc_q   <= '0;
      row_q     <= 3'd0;
      frame_q   <= 7'd0;
      dot_col_q <= 8'h00;
      dot_row_q <= 8'hFF;
    end else begin
      if (presc_q == PS_W'(SCAN_DIV - 1)) begin
        presc_q <= '0;
        row_q   <= row_q + 3'd1;
        if (row_q == 3'd7) frame_q <= pend_q;
      end else begin
        presc_q <= presc_q + PS_W'(1);
      end
      dot_row_q <= ~(8'h80 >> row_q);
      dot_col_q <= col_d;
    end
  end

  assign seven     = seven_q;
  assign bcd_out   = bcd_q;
  assign overflow  = ovf_q;
  assign conv_busy = busy_q;
  assign dot_col   = dot_col_q;
  assign dot_row   = dot_row_q;
endmodule

// File: tb/tb_score_display_ctrl.sv
// Randomised and directed bench for score_display_ctrl against a decimal-arithmetic model.
module tb_score_display_ctrl;
  localparam int W = 14, ND = 4, LB = 1, U = 7, SD = 1;

  logic clk2 = 1'b0, reset = 1'b1;
  logic [W-1:0] score = '0;
  logic [7*ND-1:0] seven;
  logic [4*ND-1:0] bcd_out;
  logic overflow, conv_busy;
  logic [7:0] dot_col, dot_row;

  score_display_ctrl #(.SCORE_W(W), .NUM_DIGITS(ND), .LEAD_BLANK(LB), .UNIT_LOG2(U), .SCAN_DIV(SD)) dut (
    .clk2(clk2), .reset(reset), .score(score), .seven(seven), .bcd_out(bcd_out),
    .overflow(overflow), .conv_busy(conv_busy), .dot_col(dot_col), .dot_row(dot_row)
  );

  always #5 clk2 = ~clk2;

  int n_tests = 0, n_fail = 0;
  logic [6:0] segtab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  localparam logic [7*ND-1:0] RST7 = {7'h7F, 7'h7F, 7'h7F, 7'b1000000};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int p10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // Number of lit dots in row r, turned into a left-aligned column pattern.
  function automatic logic [7:0] col_of(input int lit, input int r);
    int n = lit - 8 * r;
    if (n < 0) n = 0;
    if (n > 8) n = 8;
    return 8'((255 << (8 - n)) & 255);
  endfunction

  // Reference model state
  int m_last = 0, m_cnt = 0, m_cyc = 0, m_pend = 0, m_frame = 0;
  bit m_valid = 0;
  logic [7*ND-1:0] e_seven = RST7;
  logic [4*ND-1:0] e_bcd = '0;
  logic e_ovf = 0, e_busy = 0;
  logic [7:0] e_col = 8'h00, e_row = 8'hFF;

  always @(posedge clk2) begin
    if (reset) begin
      m_last = 0; m_cnt = 0; m_cyc = 0; m_pend = 0; m_frame = 0; m_valid = 0;
      e_seven = RST7; e_bcd = '0; e_ovf = 0; e_busy = 0; e_col = 8'h00; e_row = 8'hFF;
    end else begin
      int rb, ra;
      rb = (m_cyc / SD) % 8;
      ra = ((m_cyc + 1) / SD) % 8;
      e_row = ~(8'h80 >> rb);
      e_col = col_of(m_frame, rb);
      if (rb == 7 && ra == 0) m_frame = m_pend;
      m_cyc++;
      if (m_cnt == 0) begin
        if (!m_valid || int'(score) != m_last) begin
          m_last = int'(score); m_valid = 1; m_cnt = W + 1; e_busy = 1;
        end
      end else begin
        m_cnt--;
        if (m_cnt == 0) begin
          e_busy = 0;
          e_ovf = (m_last >= p10(ND));
          for (int i = 0; i < ND; i++) begin
            int d;
            d = e_ovf ? 9 : (m_last / p10(i)) % 10;
            e_bcd[4*i +: 4] = 4'(d);
            e_seven[7*i +: 7] = (LB != 0 && !e_ovf && i > 0 && m_last < p10(i)) ? 7'h7F : segtab[d];
          end
          m_pend = ((m_last >> U) > 64) ? 64 : (m_last >> U);
        end
      end
    end
  end

  always @(negedge clk2) begin
    check("seven", 64'(seven), 64'(e_seven));
    check("bcd_out", 64'(bcd_out), 64'(e_bcd));
    check("overflow", 64'(overflow), 64'(e_ovf));
    check("conv_busy", 64'(conv_busy), 64'(e_busy));
    check("dot_col", 64'(dot_col), 64'(e_col));
    check("dot_row", 64'(dot_row), 64'(e_row));
  end

  task automatic apply(input int v);
    @(negedge clk2);
    score = W'(v);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk2);
  endtask

  initial begin
    int busy_cnt, found;
    logic [7:0] rr;
    step(4);
    check("lit_rst_seven", 64'(seven), 64'(RST7));
    check("lit_rst_row", 64'(dot_row), 64'hFF);
    reset = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk2);
      if (conv_busy) busy_cnt++;
    end
    check("lit_busy_pulse", 64'(busy_cnt), 64'(W + 1));
    check("lit_zero_seven", 64'(seven), 64'(RST7));

    apply(1234);
    step(W + 1);
    check("lit_1234_busy", 64'(conv_busy), 64'd1);
    check("lit_1234_old", 64'(bcd_out), 64'h0);
    step(1);
    check("lit_1234_bcd", 64'(bcd_out), 64'h1234);
    check("lit_1234_d3", 64'(seven[27:21]), 64'(7'b1111001));
    check("lit_1234_d2", 64'(seven[20:14]), 64'(7'b0100100));
    check("lit_1234_d1", 64'(seven[13:7]), 64'(7'b0110000));
    check("lit_1234_d0", 64'(seven[6:0]), 64'(7'b0011001));
    check("lit_1234_ovf", 64'(overflow), 64'd0);
    step(40);

    apply(10000);
    step(W + 2);
    check("lit_ovf", 64'(overflow), 64'd1);
    check("lit_ovf_bcd", 64'(bcd_out), 64'h9999);
    check("lit_ovf_seven", 64'(seven), 64'({4{7'b0010000}}));
    step(20);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk2);
      check("lit_sat_col", 64'(dot_col), 64'hFF);
    end

    apply(640);
    step(W + 2 + 20);
    found = 0;
    for (int k = 0; k < 16 && found == 0; k++) begin
      @(negedge clk2);
      if (dot_row == 8'h7F) found = 1;
    end
    check("lit_row0_found", 64'(found), 64'd1);
    check("lit_640_row0", 64'(dot_col), 64'hF8);
    for (int k = 1; k < 8; k++) begin
      step(SD);
      rr = 8'h80;
      rr = ~(rr >> k);
      check("lit_640_row", 64'(dot_row), 64'(rr));
      check("lit_640_col", 64'(dot_col), 64'h00);
    end

    apply(100);
    step(5);
    score = W'(205);
    step(2 * (W + 2) + 4);
    check("lit_205_bcd", 64'(bcd_out), 64'h0205);
    check("lit_205_d3", 64'(seven[27:21]), 64'h7F);
    check("lit_205_d1", 64'(seven[13:7]), 64'(7'b1000000));

    apply(4321);
    step(5);
    reset = 1'b1;
    step(1);
    check("lit_mid_rst_bcd", 64'(bcd_out), 64'h0);
    check("lit_mid_rst_busy", 64'(conv_busy), 64'd0);
    check("lit_mid_rst_seven", 64'(seven), 64'(RST7));
    check("lit_mid_rst_col", 64'(dot_col), 64'h00);
    check("lit_mid_rst_row", 64'(dot_row), 64'hFF);
    reset = 1'b0;
    step(W + 1);
    check("lit_rel_busy", 64'(conv_busy), 64'd1);
    step(1);
    check("lit_rel_bcd", 64'(bcd_out), 64'h4321);

    for (int it = 0; it < 250; it++) begin
      int sel, v;
      sel = $urandom_range(0, 9);
      case (sel)
        0: v = 0;
        1: v = 9999;
        2: v = 10000;
        3: v = (1 << W) - 1;
        4: v = 64 << U;
        default: v = $urandom_range(0, (1 << W) - 1);
      endcase
      apply(v);
      if ($urandom_range(0, 29) == 0) begin
        reset = 1'b1;
        step($urandom_range(1, 3));
        reset = 1'b0;
      end
      step($urandom_range(1, 40));
    end
    step(3 * (W + 2) + 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
